// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory req/ack fetch bus
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch stage: owns PC, fetches words, feeds IF/ID
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_in,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            ins_out,
    output logic [31:0]            pc_4_out,
    output logic                   if_id_reg_ctrl
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] addr_q, addr_nx;
    logic        req_q, req_nx;
    logic [31:0] ins_q, ins_nx;
    logic [31:0] pc4_q, pc4_nx;
    logic        ctrl_q, ctrl_nx;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;

    assign tgt      = redirect_pc & ~32'd3;
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = REQ;
            REQ: begin
                if (redirect_valid) begin
                    state_nx = imem.imem_ack ? REQ : DRAIN;
                end else if (imem.imem_ack) begin
                    state_nx = stall_in ? HOLD : REQ;
                end
            end
            HOLD: begin
                if (redirect_valid || !stall_in) begin
                    state_nx = REQ;
                end
            end
            // An ack closes the abandoned request even if another redirect lands on the same edge.
            DRAIN: begin
                if (imem.imem_ack) begin
                    state_nx = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pc_nx   = pc;
        req_nx  = req_q;
        ins_nx  = ins_q;
        pc4_nx  = pc4_q;
        ctrl_nx = 1'b0;
        if (state != IDLE && redirect_valid) begin
            pc_nx   = tgt;
            ins_nx  = NOP_INSN;
            pc4_nx  = tgt;
            ctrl_nx = 1'b1;
        end
        case (state)
            IDLE: req_nx = 1'b1;
            REQ: begin
                if (!redirect_valid && imem.imem_ack) begin
                    ins_nx  = imem.imem_rdata;
                    pc4_nx  = pc_plus4;
                    pc_nx   = pc_plus4;
                    ctrl_nx = !stall_in;
                    req_nx  = !stall_in;
                end
            end
            HOLD: begin
                if (redirect_valid || !stall_in) begin
                    req_nx  = 1'b1;
                    ctrl_nx = 1'b1;
                end
            end
            default: ;
        endcase
        // While draining, the bus keeps the abandoned address until memory acks it.
        addr_nx = (state_nx == DRAIN) ? addr_q : pc_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            req_q  <= 1'b0;
            ins_q  <= NOP_INSN;
            pc4_q  <= 32'd0;
            ctrl_q <= 1'b0;
        end else begin
            pc     <= pc_nx;
            addr_q <= addr_nx;
            req_q  <= req_nx;
            ins_q  <= ins_nx;
            pc4_q  <= pc4_nx;
            ctrl_q <= ctrl_nx;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign ins_out        = ins_q;
    assign pc_4_out       = pc4_q;
    assign if_id_reg_ctrl = ctrl_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ins_out, pc_4_out;
    logic        if_id_reg_ctrl;

    logic        w_stall, w_redirect;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_ins, w_pc4;
    logic        w_ctrl;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [63:0] exp_q[$];

    if_fetch_unit_if mem();
    if_fetch_unit_if wmem();

    if_fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (mem.master),
        .ins_out        (ins_out),
        .pc_4_out       (pc_4_out),
        .if_id_reg_ctrl (if_id_reg_ctrl)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (w_stall),
        .redirect_valid (w_redirect),
        .redirect_pc    (w_redirect_pc),
        .imem           (wmem.master),
        .ins_out        (w_ins),
        .pc_4_out       (w_pc4),
        .if_id_reg_ctrl (w_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every IF/ID write is matched against the oldest expected {ins, pc+4}.
    always @(negedge clk) begin
        if (!rst && if_id_reg_ctrl === 1'b1) begin
            logic [63:0] e;
            vec_cnt++;
            assert (exp_q.size() != 0) else begin
                err_cnt++;
                $error("FAIL unexpected_word observed=%h_%h expected=none", ins_out, pc_4_out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vec_cnt++;
                assert ({ins_out, pc_4_out} === e) else begin
                    err_cnt++;
                    $error("FAIL ifid_word observed=%h_%h expected=%h_%h",
                           ins_out, pc_4_out, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        mem.imem_ack = 1'b0;
        mem.imem_rdata = 32'd0;
        w_stall = 1'b0;
        w_redirect = 1'b0;
        w_redirect_pc = 32'd0;
        wmem.imem_ack = 1'b0;
        wmem.imem_rdata = 32'd0;

        step();
        step();
        chk("rst_req", mem.imem_req, 32'd0);
        chk("rst_ctrl", if_id_reg_ctrl, 32'd0);
        chk("rst_ins", ins_out, 32'h13);
        chk("rst_pc4", pc_4_out, 32'd0);
        chk("rst_addr", mem.imem_addr, 32'd0);

        // zero-wait stream
        rst = 1'b0;
        step();
        chk("idle_req", mem.imem_req, 32'd1);
        chk("addr0", mem.imem_addr, 32'd0);
        chk("wrap_addr0", wmem.imem_addr, 32'hFFFF_FFFC);
        mem.imem_ack = 1'b1;
        mem.imem_rdata = 32'hA0;
        exp_q.push_back({32'hA0, 32'h4});
        wmem.imem_ack = 1'b1;
        wmem.imem_rdata = 32'hCAFE;
        step();
        chk("addr4", mem.imem_addr, 32'h4);
        chk("wrap_pc4", w_pc4, 32'd0);
        chk("wrap_ins", w_ins, 32'hCAFE);
        chk("wrap_ctrl", w_ctrl, 32'd1);
        chk("wrap_addr", wmem.imem_addr, 32'd0);
        wmem.imem_ack = 1'b0;
        mem.imem_rdata = 32'hA1;
        exp_q.push_back({32'hA1, 32'h8});
        step();
        chk("addr8", mem.imem_addr, 32'h8);
        mem.imem_rdata = 32'hA2;
        exp_q.push_back({32'hA2, 32'hC});
        step();
        chk("addrC", mem.imem_addr, 32'hC);
        mem.imem_ack = 1'b0;
        step();
        chk("stream_idle_ctrl", if_id_reg_ctrl, 32'd0);

        // stall at ack: word parks for three cycles
        mem.imem_ack = 1'b1;
        mem.imem_rdata = 32'h1234;
        stall_in = 1'b1;
        exp_q.push_back({32'h1234, 32'h10});
        step();
        mem.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_ctrl", if_id_reg_ctrl, 32'd0);
            chk("hold_req", mem.imem_req, 32'd0);
            chk("hold_ins", ins_out, 32'h1234);
            if (i < 2) step();
        end
        stall_in = 1'b0;
        step();
        chk("release_ctrl", if_id_reg_ctrl, 32'd1);
        chk("release_req", mem.imem_req, 32'd1);
        chk("release_addr", mem.imem_addr, 32'h10);

        // redirect while a fetch is outstanding
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        exp_q.push_back({32'h13, 32'h100});
        step();
        redirect_valid = 1'b0;
        chk("flush_ctrl", if_id_reg_ctrl, 32'd1);
        chk("drain_addr_a", mem.imem_addr, 32'h10);
        chk("drain_req", mem.imem_req, 32'd1);
        step();
        chk("drain_addr_b", mem.imem_addr, 32'h10);
        mem.imem_ack = 1'b1;
        mem.imem_rdata = 32'hDEAD;
        step();
        mem.imem_ack = 1'b0;
        chk("drain_discard_ctrl", if_id_reg_ctrl, 32'd0);
        chk("redir_addr", mem.imem_addr, 32'h100);

        // park a word, then redirect to an unaligned target under stall
        mem.imem_ack = 1'b1;
        mem.imem_rdata = 32'h55;
        stall_in = 1'b1;
        step();
        mem.imem_ack = 1'b0;
        chk("park_req", mem.imem_req, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        exp_q.push_back({32'h13, 32'h200});
        step();
        redirect_valid = 1'b0;
        stall_in = 1'b0;
        chk("stall_flush_ctrl", if_id_reg_ctrl, 32'd1);
        chk("stall_flush_addr", mem.imem_addr, 32'h200);
        chk("stall_flush_req", mem.imem_req, 32'd1);
        mem.imem_ack = 1'b1;
        mem.imem_rdata = 32'h77;
        exp_q.push_back({32'h77, 32'h204});
        step();
        chk("after_redir_addr", mem.imem_addr, 32'h204);

        // async reset between edges while a word is being delivered
        mem.imem_rdata = 32'h88;
        step();
        mem.imem_ack = 1'b0;
        chk("pre_rst_ctrl", if_id_reg_ctrl, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_req", mem.imem_req, 32'd0);
        chk("arst_ctrl", if_id_reg_ctrl, 32'd0);
        chk("arst_ins", ins_out, 32'h13);
        step();
        rst = 1'b0;
        step();
        chk("restart_req", mem.imem_req, 32'd1);
        chk("restart_addr", mem.imem_addr, 32'd0);
        step();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
